spm_tdp_ram: RTL and testbench
==============================

// Module: spm_tdp_ram
// PURPOSE
//  Parametrised true dual-port scratchpad RAM, single clock; successor to the fixed-width SPM RAM.
//  Adds per-byte write enables, selectable read latency, read-valid strobes, deterministic
//  collision resolution and a post-reset hardware clear. Sits between CPU IF/MEM stages and SPM.
// PARAMETERS
//  DATA_W   32    word width in bits; multiple of 8
//  ADDR_W   12    address width; DEPTH = 2**ADDR_W words
//  RD_LAT   1     read latency in cycles, 1 or 2 (2 adds an output register stage)
//  CLR_EN   1     1: zero all words after reset; 0: skip clear, ready right after reset
// PORTS
//  clk      in   1             single clock, rising edge
//  reset    in   1             asynchronous reset, active-low
//  ena      in   1             port A access request
//  wea      in   DATA_W/8      port A byte write enables (0 = read)
//  addra    in   ADDR_W        port A address
//  dia      in   DATA_W        port A write data
//  doa      out  DATA_W        port A read data
//  vala     out  1             port A doa valid strobe
//  enb/web/addrb/dib/dob/valb  port B, same widths and meaning as A
//  busy     out  1             clear in progress; all requests ignored
//  coll     out  1             1-cycle pulse: same-address conflict with >=1 write
//  perr_a   out  1             port A parity error (DPRAM_PARITY_EN only, else tied 0)
//  perr_b   out  1             port B parity error (DPRAM_PARITY_EN only, else tied 0)
// BEHAVIOUR
//  Reset (reset=0): doa/dob=0, vala/valb=0, coll=0, perr_*=0, clear counter=0.
//   If CLR_EN=1, busy=1; otherwise busy=0. RAM contents are not reset directly.
//  FSM: CLEAR -> READY.
//   CLEAR writes 0 to addr cnt, one word per cycle, cnt 0..DEPTH-1.
//   After writing DEPTH-1, state goes READY and busy drops on the next cycle.
//   CLEAR lasts exactly DEPTH cycles. CLR_EN=0 enters READY directly from reset.
//  Reset asserted mid-clear aborts it; the clear restarts from addr 0.
//  In CLEAR, en*/we* are ignored, val* stay 0 and no coll pulse is generated.
//  Access (READY): en*=1 with we*!=0 writes the enabled bytes only.
//  Any en*=1 access (read or write) returns the word after RD_LAT cycles with val*=1.
//  Same-port read-during-write is write-first: do* shows the merged new word.
//  Cross-port, same address:
//   - A writes, B reads: B returns A's new data (forwarded).
//   - Both write: per byte, A wins where wea is set; B's bytes land only where wea=0.
//     Both ports return the resulting merged word.
//   - coll=1 for one cycle, aligned with the access cycle +1, whenever one port writes.
//   - Both read: no coll; both return the stored word.
//  do* holds its last value when val*=0; it is never cleared except by reset.
//  RD_LAT=2: data and val pipelined one extra register; new requests are accepted every cycle.
//  Addresses wrap naturally at ADDR_W bits; no out-of-range condition exists.
// CONFIGURATION
//  DPRAM_PARITY_EN defined:
//   - one even-parity bit stored per byte; write path generates it, read path checks it.
//   - perr_a/perr_b pulse with val* when any returned byte mismatches; data is still returned.
//   - CLEAR writes 0 data with parity 0.
//  DPRAM_PARITY_EN undefined: no parity storage; perr_a/perr_b tied 0.
// TESTING
//  1 Reset, CLR_EN=1, ADDR_W=4 -> busy=1 for 16 cycles; every address then reads 0 with vala=1.
//  2 A writes 0xAABBCCDD wea=4'b1111 @3, then wea=4'b0010 dia=0x00001100
//    -> read @3 = 0xAABB11DD, after 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2).
//  3 Same cycle: A writes 0x11111111 @5, B reads @5 -> dob=0x11111111, coll pulses 1 cycle.
//  4 Same cycle: A wea=4'b0011 dia=0x0000AAAA, B web=4'b1111 dib=0xBBBBBBBB @7
//    -> mem[7]=0xBBBBAAAA, coll=1.
//  5 Reset pulsed at clear cycle 8 -> busy stays 1; clear restarts at 0 and completes in 16 cycles.
//  6 DPRAM_PARITY_EN: force a bit flip in a stored byte, then read -> perr_a=1 together with vala.

Source files
------------

// File: rtl/spm_tdp_ram.sv
// True dual-port scratchpad RAM with byte enables, 1/2-cycle read latency and a post-reset clear.
// Optional per-byte even parity when DPRAM_PARITY_EN is defined.
module spm_tdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1,
  parameter int CLR_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dia,
  output logic [DATA_W-1:0]     doa,
  output logic                  vala,
  input  logic                  enb,
  input  logic [DATA_W/8-1:0]   web,
  input  logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_W-1:0]     dib,
  output logic [DATA_W-1:0]     dob,
  output logic                  valb,
  output logic                  busy,
  output logic                  coll,
  output logic                  perr_a,
  output logic                  perr_b,
  output logic                  state_dbg
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;
  logic                clr_we;
  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [NB-1:0] be,
                                              input logic [DATA_W-1:0] d);
    merge = old;
    for (int i = 0; i < NB; i++)
      if (be[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= (CLR_EN != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (&cnt) state_nx = READY;
      end
      READY:   state_nx = READY;
      default: state_nx = READY;
    endcase
  end

  assign busy      = (state == CLEAR);
  assign state_dbg = (state == READY);

  logic acc_a, acc_b, wr_a, wr_b, same;
  logic [NB-1:0]     bmask_a, amask_b;
  logic [DATA_W-1:0] new_a, new_b;

  assign acc_a   = (state == READY) && ena;
  assign acc_b   = (state == READY) && enb;
  assign wr_a    = acc_a && (|wea);
  assign wr_b    = acc_b && (|web);
  assign same    = (addra == addrb);
  // Each port sees the other port's bytes at a shared address; A's bytes always win.
  assign bmask_a = (acc_b && same) ? web : '0;
  assign amask_b = (acc_a && same) ? wea : '0;
  assign new_a   = merge(merge(mem[addra], bmask_a, dib), wea, dia);
  assign new_b   = merge(merge(mem[addrb], web, dib), amask_b, dia);

  always_ff @(posedge clk) begin
    if (clr_we) mem[cnt] <= '0;
    if (wr_b)   mem[addrb] <= new_b;
    if (wr_a)   mem[addra] <= new_a;
  end

  logic perr_a_c, perr_b_c;
`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] npar_a, npar_b;

  function automatic logic [NB-1:0] pgen(input logic [DATA_W-1:0] w);
    for (int i = 0; i < NB; i++) pgen[i] = ^w[8*i +: 8];
  endfunction

  function automatic logic [NB-1:0] pmerge(input logic [NB-1:0] old, input logic [NB-1:0] be,
                                           input logic [NB-1:0] p);
    pmerge = (old & ~be) | (p & be);
  endfunction

  assign npar_a   = pmerge(pmerge(par[addra], bmask_a, pgen(dib)), wea, pgen(dia));
  assign npar_b   = pmerge(pmerge(par[addrb], web, pgen(dib)), amask_b, pgen(dia));
  assign perr_a_c = |(npar_a ^ pgen(new_a));
  assign perr_b_c = |(npar_b ^ pgen(new_b));

  always_ff @(posedge clk) begin
    if (clr_we) par[cnt] <= '0;
    if (wr_b)   par[addrb] <= npar_b;
    if (wr_a)   par[addra] <= npar_a;
  end
`else
  assign perr_a_c = 1'b0;
  assign perr_b_c = 1'b0;
`endif

  logic [DATA_W-1:0] d1_a, d1_b;
  logic              v1_a, v1_b, p1_a, p1_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1_a <= '0;   d1_b <= '0;
      v1_a <= 1'b0; v1_b <= 1'b0;
      p1_a <= 1'b0; p1_b <= 1'b0;
      coll <= 1'b0;
    end else begin
      v1_a <= acc_a;
      v1_b <= acc_b;
      p1_a <= acc_a && perr_a_c;
      p1_b <= acc_b && perr_b_c;
      if (acc_a) d1_a <= new_a;
      if (acc_b) d1_b <= new_b;
      coll <= acc_a && acc_b && same && (wr_a || wr_b);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] d2_a, d2_b;
      logic              v2_a, v2_b, p2_a, p2_b;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          d2_a <= '0;   d2_b <= '0;
          v2_a <= 1'b0; v2_b <= 1'b0;
          p2_a <= 1'b0; p2_b <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          p2_a <= p1_a;
          p2_b <= p1_b;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end
      assign doa = d2_a;  assign vala = v2_a;  assign perr_a = p2_a;
      assign dob = d2_b;  assign valb = v2_b;  assign perr_b = p2_b;
    end else begin : g_lat1
      assign doa = d1_a;  assign vala = v1_a;  assign perr_a = p1_a;
      assign dob = d1_b;  assign valb = v1_b;  assign perr_b = p1_b;
    end
  endgenerate
endmodule

// File: tb/tb_spm_tdp_ram.sv
// Bench for spm_tdp_ram: RD_LAT=1 and RD_LAT=2 instances share stimulus, plus a CLR_EN=0 instance.
// Parity fault injection runs only when DPRAM_PARITY_EN is defined.
module tb_spm_tdp_ram;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0, addra = '0, addrb = '0;
  logic [31:0] dia = '0, dib = '0;

  logic [31:0] doa1, dob1, doa2, dob2, doa3, dob3;
  logic vala1, valb1, coll1, busy1, pea1, peb1, st1;
  logic vala2, valb2, coll2, busy2, pea2, peb2, st2;
  logic vala3, valb3, coll3, busy3, pea3, peb3, st3;

  always #5 clk = ~clk;

  spm_tdp_ram #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLR_EN(1)) dut (
    .clk(clk), .reset(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa1),
    .vala(vala1), .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob1), .valb(valb1),
    .busy(busy1), .coll(coll1), .perr_a(pea1), .perr_b(peb1), .state_dbg(st1));
  spm_tdp_ram #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .CLR_EN(1)) dut2 (
    .clk(clk), .reset(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa2),
    .vala(vala2), .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob2), .valb(valb2),
    .busy(busy2), .coll(coll2), .perr_a(pea2), .perr_b(peb2), .state_dbg(st2));
  spm_tdp_ram #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLR_EN(0)) dut3 (
    .clk(clk), .reset(rst_n), .ena(1'b0), .wea(4'h0), .addra(4'h0), .dia(32'h0), .doa(doa3),
    .vala(vala3), .enb(1'b0), .web(4'h0), .addrb(4'h0), .dib(32'h0), .dob(dob3), .valb(valb3),
    .busy(busy3), .coll(coll3), .perr_a(pea3), .perr_b(peb3), .state_dbg(st3));

  int checks = 0, errors = 0, cyc = 0;
  logic chk_on = 1'b0, ready_tb = 1'b0, coll_exp = 1'b0, pe_next = 1'b0;
  logic [31:0] model [16];
  logic [31:0] exp_q [4][$];
  int          due_q [4][$];
  logic        pe_q  [4][$];
  logic [31:0] last [4];
  logic [31:0] obs_d [4];
  logic        obs_v [4], obs_p [4];
  logic        ca_en, cb_en;
  logic [3:0]  ca_we, cb_we, ca_ad, cb_ad;
  logic [31:0] ca_di, cb_di;

  assign obs_d[0] = doa1;  assign obs_v[0] = vala1;  assign obs_p[0] = pea1;
  assign obs_d[1] = dob1;  assign obs_v[1] = valb1;  assign obs_p[1] = peb1;
  assign obs_d[2] = doa2;  assign obs_v[2] = vala2;  assign obs_p[2] = pea2;
  assign obs_d[3] = dob2;  assign obs_v[3] = valb2;  assign obs_p[3] = peb2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    coll_exp <= ready_tb && ena && enb && (addra == addrb) && (wea != 4'h0 || web != 4'h0);
  end

  // Scoreboard side: every valid output pops the oldest expectation for that port.
  always @(negedge clk) begin
    if (chk_on) begin
      if (!rst_n) begin
        for (int p = 0; p < 4; p++) last[p] = '0;
      end else begin
        chk("coll1", {31'b0, coll1}, {31'b0, coll_exp});
        chk("coll2", {31'b0, coll2}, {31'b0, coll_exp});
        for (int p = 0; p < 4; p++) begin
          if (obs_v[p]) begin
            if (exp_q[p].size() == 0) begin
              chk($sformatf("val_spurious%0d", p), 32'd1, 32'd0);
            end else begin
              chk($sformatf("rdata%0d", p), obs_d[p], exp_q[p].pop_front());
              chk($sformatf("lat%0d", p), cyc, due_q[p].pop_front());
              chk($sformatf("perr%0d", p), {31'b0, obs_p[p]}, {31'b0, pe_q[p].pop_front()});
            end
            last[p] = obs_d[p];
          end else begin
            chk($sformatf("hold%0d", p), obs_d[p], last[p]);
            chk($sformatf("perr_idle%0d", p), {31'b0, obs_p[p]}, 32'd0);
          end
        end
      end
    end
  end

  // Post-access word at an address: A's enabled bytes win, then B's, else the stored byte.
  function automatic logic [31:0] resolve(input logic [3:0] ad);
    logic [31:0] w;
    w = model[ad];
    for (int i = 0; i < 4; i++) begin
      if (ca_en && ca_ad == ad && ca_we[i])      w[8*i +: 8] = ca_di[8*i +: 8];
      else if (cb_en && cb_ad == ad && cb_we[i]) w[8*i +: 8] = cb_di[8*i +: 8];
    end
    return w;
  endfunction

  task automatic access(input logic a_en, input logic [3:0] a_we, input logic [3:0] a_ad,
                        input logic [31:0] a_di, input logic b_en, input logic [3:0] b_we,
                        input logic [3:0] b_ad, input logic [31:0] b_di);
    logic [31:0] na, nb;
    @(negedge clk);
    ca_en = a_en; ca_we = a_we; ca_ad = a_ad; ca_di = a_di;
    cb_en = b_en; cb_we = b_we; cb_ad = b_ad; cb_di = b_di;
    na = resolve(a_ad);
    nb = resolve(b_ad);
    if (a_en) begin
      exp_q[0].push_back(na); due_q[0].push_back(cyc + 1); pe_q[0].push_back(pe_next);
      exp_q[2].push_back(na); due_q[2].push_back(cyc + 2); pe_q[2].push_back(pe_next);
    end
    if (b_en) begin
      exp_q[1].push_back(nb); due_q[1].push_back(cyc + 1); pe_q[1].push_back(1'b0);
      exp_q[3].push_back(nb); due_q[3].push_back(cyc + 2); pe_q[3].push_back(1'b0);
    end
    if (a_en && a_we != 4'h0) model[a_ad] = na;
    if (b_en && b_we != 4'h0) model[b_ad] = nb;
    ena = a_en; wea = a_we; addra = a_ad; dia = a_di;
    enb = b_en; web = b_we; addrb = b_ad; dib = b_di;
  endtask

  task automatic idle(input int n);
    repeat (n) access(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Hold conflicting write requests during the clear; they must all be ignored.
  task automatic run_clear(input string tag);
    int d1, d2;
    d1 = 0; d2 = 0;
    ena = 1'b1; wea = 4'hF; addra = 4'h0; dia = 32'hDEAD_BEEF;
    enb = 1'b1; web = 4'hF; addrb = 4'h0; dib = 32'hCAFE_F00D;
    for (int i = 1; i <= 40 && (d1 == 0 || d2 == 0); i++) begin
      @(negedge clk);
      if (!busy1 && d1 == 0) d1 = i;
      if (!busy2 && d2 == 0) d2 = i;
    end
    ena = 1'b0; wea = 4'h0; enb = 1'b0; web = 4'h0;
    ready_tb = 1'b1;
    for (int a = 0; a < 16; a++) model[a] = '0;
    chk({tag, "_len1"}, d1, 16);
    chk({tag, "_len2"}, d2, 16);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) model[a] = '0;
    for (int p = 0; p < 4; p++) last[p] = '0;
    repeat (3) @(negedge clk);
    chk("rst_doa", doa1, 0);      chk("rst_dob", dob2, 0);
    chk("rst_vala", {31'b0, vala1}, 0); chk("rst_valb", {31'b0, valb2}, 0);
    chk("rst_coll", {31'b0, coll1}, 0); chk("rst_busy", {31'b0, busy1}, 1);
    chk("rst_busy_lat2", {31'b0, busy2}, 1);
    chk("rst_state", {31'b0, st1}, 0);
    chk("rst_perr", {30'b0, pea1, peb2}, 0);
    chk("rst_busy_noclr", {31'b0, busy3}, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    run_clear("clr");
    chk("noclr_ready", {31'b0, st3}, 1);

    for (int a = 0; a < 16; a++) access(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(15 - a), 32'h0);
    access(1'b1, 4'hF, 4'd3, 32'hAABB_CCDD, 1'b0, 4'h0, 4'd0, 32'h0);
    access(1'b1, 4'h2, 4'd3, 32'h0000_1100, 1'b0, 4'h0, 4'd0, 32'h0);
    access(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    access(1'b1, 4'hF, 4'd5, 32'h1111_1111, 1'b1, 4'h0, 4'd5, 32'h0);
    access(1'b1, 4'h3, 4'd7, 32'h0000_AAAA, 1'b1, 4'hF, 4'd7, 32'hBBBB_BBBB);
    access(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
    access(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'h5, 4'd3, 32'h1234_5678);
    access(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    access(1'b1, 4'hF, 4'd2, 32'h0202_0202, 1'b1, 4'hF, 4'd9, 32'h0909_0909);
    idle(3);

    for (int i = 0; i < 200; i++) begin
      access(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 3)), $urandom);
    end
    for (int a = 0; a < 16; a++) access(1'b1, 4'h0, 4'(a), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(4);

`ifdef DPRAM_PARITY_EN
    access(1'b1, 4'hF, 4'd9, 32'h1234_5678, 1'b0, 4'h0, 4'd0, 32'h0);
    idle(3);
    dut.mem[9][0]  = ~dut.mem[9][0];
    dut2.mem[9][0] = ~dut2.mem[9][0];
    model[9][0]    = ~model[9][0];
    pe_next = 1'b1;
    access(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    pe_next = 1'b0;
    idle(4);
`endif

    for (int a = 8; a < 16; a++) access(1'b1, 4'hF, 4'(a), 32'h5A5A_0000 | a, 1'b0, 4'h0, 4'h0, 32'h0);
    idle(4);
    @(negedge clk);
    ready_tb = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midclr_busy", {31'b0, busy1}, 1);
    chk("midclr_busy2", {31'b0, busy2}, 1);
    rst_n = 1'b1;
    run_clear("reclr");
    for (int a = 0; a < 16; a++) access(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(a), 32'h0);
    idle(4);

    for (int p = 0; p < 4; p++) chk($sformatf("q_empty%0d", p), exp_q[p].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
